fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/ifid_reg.sv | 42 ++++
 rtl/fetch_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
// Shared constants and types for the instruction fetch stage.
//   NOP_INSTR       - bubble encoding loaded into IF/ID when it carries no work
//   OPC_HALT        - opcode that stops sequential fetch
//   OPC_MSB/OPC_LSB - bit positions of the opcode field inside an instruction
//   fetch_state_t   - fetch FSM state encoding
package fetch_stage_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam logic [3:0]  OPC_HALT  = 4'hF;
    localparam int          OPC_MSB   = 15;
    localparam int          OPC_LSB   = 12;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    function automatic logic [3:0] get_opcode(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg
// IF/ID pipeline register with clear/load/hold control. Clear wins over load;
// with neither asserted the register holds.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   load              - capture instr_d / pc_plus2_d as a valid instruction
//   clear             - replace contents with a bubble (NOP, pc_plus2 0, invalid)
//   instr_d           - instruction word to capture
//   pc_plus2_d        - sequential PC of the captured instruction
//   instr, pc_plus2   - registered IF/ID contents
//   valid             - IF/ID holds a real instruction
module ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [15:0] instr_d,
    input  logic [15:0] pc_plus2_d,
    output logic [15:0] instr,
    output logic [15:0] pc_plus2,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr    <= NOP_INSTR;
            pc_plus2 <= 16'h0000;
            valid    <= 1'b0;
        end else if (clear) begin
            instr    <= NOP_INSTR;
            pc_plus2 <= 16'h0000;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= instr_d;
            pc_plus2 <= pc_plus2_d;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch: owns the PC, drives the instruction memory address,
// fills the IF/ID register and stops on a HALT instruction.
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   stall_i        - hold PC and IF/ID
//   flush_i        - replace the instruction being latched with a bubble
//   redirect_i     - taken branch/jump; redirect_pc is the target
//   imem_addr      - instruction memory address (the PC)
//   imem_data      - instruction word read combinationally at imem_addr
//   ifid_instr     - IF/ID instruction
//   ifid_pc_plus2  - IF/ID sequential PC of that instruction
//   ifid_valid     - IF/ID holds a real instruction
//   halted         - fetch stopped on HALT
//   fetch_count    - valid instructions latched, saturating
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | sequential fetch, PC advances each unstalled cycle
// ST_HALT | HALT latched; PC frozen, IF/ID fed bubbles until redirect
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam logic [15:0] STEP16 = 16'(PC_STEP);

    logic [15:0]  pc;
    fetch_state_t state;
    logic [15:0]  pc_seq;
    logic [15:0]  redirect_target;
    logic         normal_fetch;
    logic         ifid_clear;

    assign imem_addr       = pc;
    assign pc_seq          = pc + STEP16;
    // Targets are forced halfword aligned.
    assign redirect_target = redirect_pc & 16'hFFFE;

    assign normal_fetch = !redirect_i && !flush_i && !stall_i && (state == ST_RUN);
    // A stall alone holds IF/ID; in HALT the bubble is reloaded every unstalled cycle.
    assign ifid_clear   = redirect_i || flush_i || (!stall_i && (state == ST_HALT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            state       <= ST_RUN;
            halted      <= 1'b0;
            fetch_count <= 16'h0000;
        end else if (redirect_i) begin
            pc     <= redirect_target;
            state  <= ST_RUN;
            halted <= 1'b0;
        end else if (normal_fetch) begin
            pc <= pc_seq;
            if (fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'h0001;
            end
            if (get_opcode(imem_data) == OPC_HALT) begin
                state  <= ST_HALT;
                halted <= 1'b1;
            end
        end
    end

    ifid_reg u_ifid_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (normal_fetch),
        .clear      (ifid_clear),
        .instr_d    (imem_data),
        .pc_plus2_d (pc_seq),
        .instr      (ifid_instr),
        .pc_plus2   (ifid_pc_plus2),
        .valid      (ifid_valid)
    );

endmodule
